// File: rtl/spawn_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// spawn_scheduler_pkg
//   Shared constants, FSM state encoding and small helpers for the spawn
//   scheduler of the falling-object game.
//   Contents:
//     NUM_SLOTS / SLOT_W     object slot count and index width
//     BASE_INTERVAL / CNT_W  frames between spawns at level 0, counter width
//     MAX_REPEAT             max consecutive spawns in one lane
//     MAX_RETRY              resample attempts before forced acceptance
//     HBP / LANE_PITCH /     lane geometry: lane k sits at HBP + k*LANE_PITCH
//     NUM_LANES
//     state_t                scheduler FSM states
//     interval_for()         frames per spawn for a difficulty level
//     is_lane()              1 when an x-position is exactly a lane position
// -----------------------------------------------------------------------------
package spawn_scheduler_pkg;

  localparam int NUM_SLOTS     = 8;
  localparam int SLOT_W        = $clog2(NUM_SLOTS);
  localparam int BASE_INTERVAL = 60;
  localparam int CNT_W         = 8;
  localparam int MAX_REPEAT    = 2;
  localparam int MAX_RETRY     = 7;
  localparam int HPOS_W        = 10;
  localparam int DROP_W        = 8;
  localparam int REP_W         = 4;
  localparam int RETRY_W       = $clog2(MAX_RETRY + 1);

  localparam int HBP        = 295;
  localparam int LANE_PITCH = 120;
  localparam int NUM_LANES  = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_ALLOC  = 3'd3,
    ST_ISSUE  = 3'd4
  } state_t;

  // Interval shrinks by halving per level but never reaches zero frames.
  function automatic logic [CNT_W-1:0] interval_for(input logic [1:0] level);
    logic [CNT_W-1:0] v;
    v = CNT_W'(BASE_INTERVAL) >> level;
    if (v == '0) v = CNT_W'(1);
    return v;
  endfunction

  function automatic logic is_lane(input logic [HPOS_W-1:0] hpos);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (hpos == HPOS_W'(HBP + k * LANE_PITCH)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/spawn_scheduler_slot_alloc.sv
// -----------------------------------------------------------------------------
// spawn_scheduler_slot_alloc
//   Owns the object-slot occupancy vector and finds the lowest free slot.
//   Ports:
//     i_clk, i_rst      clock, synchronous active-high reset
//     i_clear_all       free every slot (game start)
//     i_set_en/_slot    mark a slot busy (spawn handshake)
//     i_clr_en/_slot    mark a slot free (despawn report)
//     o_slot_busy       occupancy vector
//     o_free_slot       lowest-index free slot (valid when o_any_free)
//     o_any_free        at least one slot is free
// -----------------------------------------------------------------------------
module spawn_scheduler_slot_alloc
  import spawn_scheduler_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear_all,
  input  logic                 i_set_en,
  input  logic [SLOT_W-1:0]    i_set_slot,
  input  logic                 i_clr_en,
  input  logic [SLOT_W-1:0]    i_clr_slot,
  output logic [NUM_SLOTS-1:0] o_slot_busy,
  output logic [SLOT_W-1:0]    o_free_slot,
  output logic                 o_any_free
);

  logic [NUM_SLOTS-1:0] r_busy;
  logic [NUM_SLOTS-1:0] w_busy_next;

  // Per-slot next state: a set in the same cycle as a clear of that slot wins.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic w_set_hit;
      logic w_clr_hit;
      assign w_set_hit = i_set_en && (i_set_slot == SLOT_W'(gi));
      assign w_clr_hit = i_clr_en && (i_clr_slot == SLOT_W'(gi));
      assign w_busy_next[gi] = w_set_hit ? 1'b1 :
                               w_clr_hit ? 1'b0 : r_busy[gi];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear_all) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Descending scan so the lowest free index is the one left standing.
  always_comb begin
    o_free_slot = '0;
    o_any_free  = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        o_free_slot = SLOT_W'(i);
        o_any_free  = 1'b1;
      end
    end
  end

  assign o_slot_busy = r_busy;

endmodule

// File: rtl/spawn_scheduler.sv
// -----------------------------------------------------------------------------
// spawn_scheduler
//   Every spawn interval (in frames) samples the LFSR lane position, applies
//   the lane-repeat limit with bounded resampling, allocates a free object
//   slot and offers {hpos, slot} to the object engine over valid/ready.
//   Ports:
//     i_clk, i_rst        clock, synchronous active-high reset
//     i_game_en           1 = game running, 0 = return to idle
//     i_frame_tick        one-cycle pulse per video frame
//     i_level             difficulty; interval = max(1, 60 >> level)
//     i_rand_hpos         fresh lane candidate from the LFSR every cycle
//     o_rng_reseed        one-cycle pulse on game start
//     o_spawn_valid/      spawn request and its acceptance
//     i_spawn_ready
//     o_spawn_hpos/_slot  lane x-position and slot of the pending spawn
//     i_despawn_valid/    slot freed by the object engine
//     i_despawn_slot
//     o_slot_busy         slot occupancy vector
//     o_drop_cnt          saturating count of spawns dropped for lack of slots
// -----------------------------------------------------------------------------
module spawn_scheduler
  import spawn_scheduler_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_game_en,
  input  logic                 i_frame_tick,
  input  logic [1:0]           i_level,
  input  logic [HPOS_W-1:0]    i_rand_hpos,
  output logic                 o_rng_reseed,
  output logic                 o_spawn_valid,
  input  logic                 i_spawn_ready,
  output logic [HPOS_W-1:0]    o_spawn_hpos,
  output logic [SLOT_W-1:0]    o_spawn_slot,
  input  logic                 i_despawn_valid,
  input  logic [SLOT_W-1:0]    i_despawn_slot,
  output logic [NUM_SLOTS-1:0] o_slot_busy,
  output logic [DROP_W-1:0]    o_drop_cnt
);

  state_t              r_state;
  logic                r_rng_reseed;
  logic                r_spawn_valid;
  logic [HPOS_W-1:0]   r_spawn_hpos;
  logic [SLOT_W-1:0]   r_spawn_slot;
  logic [DROP_W-1:0]   r_drop_cnt;
  logic [HPOS_W-1:0]   r_last_hpos;
  logic [REP_W-1:0]    r_repeat_cnt;
  logic [RETRY_W-1:0]  r_retry_cnt;
  logic [CNT_W-1:0]    r_frame_cnt;
  logic [HPOS_W-1:0]   r_cand;

  logic                w_lane_ok;
  logic                w_repeat_block;
  logic                w_retry_last;
  logic                w_handshake;
  logic                w_clr_en;
  logic                w_clear_all;
  logic [CNT_W-1:0]    w_reload;
  logic [SLOT_W-1:0]   w_free_slot;
  logic                w_any_free;

  assign w_lane_ok      = is_lane(i_rand_hpos);
  assign w_repeat_block = (i_rand_hpos == r_last_hpos) &&
                          (r_repeat_cnt == REP_W'(MAX_REPEAT));
  assign w_retry_last   = (r_retry_cnt == RETRY_W'(MAX_RETRY));
  // An abort (game_en low) in the handshake cycle wins: nothing is committed.
  assign w_handshake    = (r_state == ST_ISSUE) && r_spawn_valid &&
                          i_spawn_ready && i_game_en;
  assign w_clr_en       = (r_state != ST_IDLE) && i_despawn_valid;
  assign w_clear_all    = (r_state == ST_IDLE) && i_game_en;
  // Level is only looked at when a count is (re)loaded.
  assign w_reload       = interval_for(i_level);

  spawn_scheduler_slot_alloc u_slot_alloc (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear_all (w_clear_all),
    .i_set_en    (w_handshake),
    .i_set_slot  (r_spawn_slot),
    .i_clr_en    (w_clr_en),
    .i_clr_slot  (i_despawn_slot),
    .o_slot_busy (o_slot_busy),
    .o_free_slot (w_free_slot),
    .o_any_free  (w_any_free)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_rng_reseed  <= 1'b0;
      r_spawn_valid <= 1'b0;
      r_spawn_hpos  <= HPOS_W'(HBP);
      r_spawn_slot  <= '0;
      r_drop_cnt    <= '0;
      r_last_hpos   <= HPOS_W'(HBP);
      r_repeat_cnt  <= '0;
      r_retry_cnt   <= '0;
      r_frame_cnt   <= '0;
      r_cand        <= HPOS_W'(HBP);
    end else begin
      r_rng_reseed <= 1'b0;
      if ((r_state != ST_IDLE) && !i_game_en) begin
        r_state       <= ST_IDLE;
        r_spawn_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_game_en) begin
              r_rng_reseed <= 1'b1;
              r_frame_cnt  <= w_reload;
              r_state      <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            // Ticks arriving outside WAIT are simply not seen here.
            if (i_frame_tick) begin
              if (r_frame_cnt <= CNT_W'(1)) begin
                r_retry_cnt <= '0;
                r_state     <= ST_SAMPLE;
              end else begin
                r_frame_cnt <= r_frame_cnt - 1'b1;
              end
            end
          end
          ST_SAMPLE: begin
            if (w_lane_ok && !w_repeat_block) begin
              r_cand  <= i_rand_hpos;
              r_state <= ST_ALLOC;
            end else if (w_retry_last) begin
              // Out of retries: a legal lane is taken even if it repeats,
              // garbage is replaced by the first lane.
              r_cand  <= w_lane_ok ? i_rand_hpos : HPOS_W'(HBP);
              r_state <= ST_ALLOC;
            end else begin
              r_retry_cnt <= r_retry_cnt + 1'b1;
            end
          end
          ST_ALLOC: begin
            if (w_any_free) begin
              r_spawn_slot  <= w_free_slot;
              r_spawn_hpos  <= r_cand;
              r_spawn_valid <= 1'b1;
              r_state       <= ST_ISSUE;
            end else begin
              if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
              r_frame_cnt <= w_reload;
              r_state     <= ST_WAIT;
            end
          end
          ST_ISSUE: begin
            if (w_handshake) begin
              r_spawn_valid <= 1'b0;
              r_last_hpos   <= r_spawn_hpos;
              if (r_spawn_hpos == r_last_hpos) begin
                if (r_repeat_cnt != '1) r_repeat_cnt <= r_repeat_cnt + 1'b1;
              end else begin
                r_repeat_cnt <= REP_W'(1);
              end
              r_frame_cnt <= w_reload;
              r_state     <= ST_WAIT;
            end
          end
          default: begin
            r_state       <= ST_IDLE;
            r_spawn_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_rng_reseed  = r_rng_reseed;
  assign o_spawn_valid = r_spawn_valid;
  assign o_spawn_hpos  = r_spawn_hpos;
  assign o_spawn_slot  = r_spawn_slot;
  assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spawn_scheduler
//   Randomized bench for spawn_scheduler. A spawn-level model (slot table,
//   lane history, frame budget, drop count) predicts every spawn: which lane
//   the resampling rules settle on, how many attempts it takes, which slot is
//   handed out, and when a spawn is dropped instead.
// -----------------------------------------------------------------------------
module tb_spawn_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       game_en = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] level = 2'd0;
  logic [9:0] rand_hpos = 10'd0;
  logic       rng_reseed;
  logic       spawn_valid;
  logic       spawn_ready = 1'b0;
  logic [9:0] spawn_hpos;
  logic [2:0] spawn_slot;
  logic       despawn_valid = 1'b0;
  logic [2:0] despawn_slot = 3'd0;
  logic [7:0] slot_busy;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  spawn_scheduler dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_game_en      (game_en),
    .i_frame_tick   (frame_tick),
    .i_level        (level),
    .i_rand_hpos    (rand_hpos),
    .o_rng_reseed   (rng_reseed),
    .o_spawn_valid  (spawn_valid),
    .i_spawn_ready  (spawn_ready),
    .o_spawn_hpos   (spawn_hpos),
    .o_spawn_slot   (spawn_slot),
    .i_despawn_valid(despawn_valid),
    .i_despawn_slot (despawn_slot),
    .o_slot_busy    (slot_busy),
    .o_drop_cnt     (drop_cnt)
  );

  int total = 0;
  int bad   = 0;
  int n_spawn = 0;

  // Reference model state
  bit m_busy[8];
  int m_last;
  int m_rep;
  int m_drop;
  int m_cnt;
  int vals[16];
  int lanes[3] = '{295, 415, 535};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int interval(input int lvl);
    int v;
    v = 60 / (1 << lvl);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic bit lane_legal(input int v);
    return (v == 295) || (v == 415) || (v == 535);
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < 8; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] busy_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Attempt r looks at vals[r]; the last allowed attempt takes what it gets.
  task automatic pick_lane(output int hpos, output int tries);
    hpos = 295;
    tries = 8;
    for (int r = 0; r < 8; r++) begin
      if (lane_legal(vals[r]) && !(vals[r] == m_last && m_rep == 2)) begin
        hpos = vals[r];
        tries = r + 1;
        return;
      end
      if (r == 7) begin
        hpos = lane_legal(vals[r]) ? vals[r] : 295;
        tries = 8;
        return;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
    m_last = 295;
    m_rep  = 0;
    m_drop = 0;
    m_cnt  = 0;
  endtask

  task automatic check_reset_values(input string where);
    chk({where, "_valid"},  spawn_valid, 0);
    chk({where, "_hpos"},   spawn_hpos, 295);
    chk({where, "_slot"},   spawn_slot, 0);
    chk({where, "_busy"},   slot_busy, 0);
    chk({where, "_reseed"}, rng_reseed, 0);
    chk({where, "_drop"},   drop_cnt, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; game_en = 1'b0; frame_tick = 1'b0;
    spawn_ready = 1'b0; despawn_valid = 1'b0;
    step();
    check_reset_values("rst");
    rst = 1'b0;
    model_reset();
    $display("reset applied");
  endtask

  task automatic start_game(input int lvl);
    level = 2'(lvl);
    game_en = 1'b1;
    step();
    chk("reseed_on", rng_reseed, 1);
    chk("start_busy_clear", slot_busy, 0);
    for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
    m_cnt = interval(lvl);
    step();
    chk("reseed_off", rng_reseed, 0);
    $display("game start level=%0d interval=%0d", lvl, m_cnt);
  endtask

  task automatic despawn(input int s);
    despawn_valid = 1'b1;
    despawn_slot = 3'(s);
    step();
    despawn_valid = 1'b0;
    m_busy[s] = 1'b0;
    chk("despawn_busy", slot_busy, busy_vec());
  endtask

  // Feeds frame ticks until the expiring one has just been sampled.
  task automatic run_ticks(input bit allow_desp);
    for (int n = m_cnt; n > 1; n--) begin
      frame_tick = 1'b1;
      rand_hpos = 10'($urandom_range(0, 1023));
      step();
      frame_tick = 1'b0;
      chk("wait_no_valid", spawn_valid, 0);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        rand_hpos = 10'($urandom_range(0, 1023));
        if (allow_desp && $urandom_range(0, 3) == 0) despawn($urandom_range(0, 7));
        else step();
      end
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // mode 0: random candidates, mode 1: constant 415.
  task automatic do_spawn(input int mode, input int ready_delay, input bit allow_desp, input bit abort);
    int hpos, tries, slot, k;
    for (int i = 0; i < 16; i++) begin
      if (mode == 1) vals[i] = 415;
      else if ($urandom_range(0, 9) < 6) vals[i] = lanes[$urandom_range(0, 2)];
      else vals[i] = $urandom_range(0, 1023);
    end
    run_ticks(allow_desp);
    pick_lane(hpos, tries);
    slot = lowest_free();
    rand_hpos = 10'(vals[0]);
    if (slot < 0) begin
      for (int e = 1; e <= tries + 1; e++) begin
        step();
        rand_hpos = 10'((e < 16) ? vals[e] : $urandom_range(0, 1023));
        chk("drop_no_valid", spawn_valid, 0);
      end
      m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      m_cnt = interval(level);
      chk("drop_cnt", drop_cnt, m_drop);
      $display("drop tries=%0d drop_cnt=%0d", tries, drop_cnt);
      return;
    end
    k = 0;
    for (int e = 1; e <= 30; e++) begin
      step();
      rand_hpos = 10'((e < 16) ? vals[e] : $urandom_range(0, 1023));
      if (spawn_valid) begin
        k = e;
        break;
      end
    end
    chk("latency", k, tries + 1);
    if (k == 0) return;
    chk("spawn_hpos", spawn_hpos, hpos);
    chk("spawn_slot", spawn_slot, slot);
    for (int d = 0; d < ready_delay; d++) begin
      frame_tick = 1'($urandom_range(0, 1));
      step();
      chk("hold_valid", spawn_valid, 1);
      chk("hold_hpos", spawn_hpos, hpos);
      chk("hold_slot", spawn_slot, slot);
    end
    frame_tick = 1'b0;
    if (abort) begin
      game_en = 1'b0;
      step();
      chk("abort_valid", spawn_valid, 0);
      step();
      chk("abort_busy_held", slot_busy, busy_vec());
      chk("abort_stay_low", spawn_valid, 0);
      $display("abort hpos=%0d slot=%0d", hpos, slot);
      return;
    end
    spawn_ready = 1'b1;
    step();
    spawn_ready = 1'b0;
    chk("post_hs_valid", spawn_valid, 0);
    m_busy[slot] = 1'b1;
    m_rep = (hpos == m_last) ? ((m_rep < 15) ? m_rep + 1 : 15) : 1;
    m_last = hpos;
    m_cnt = interval(level);
    chk("post_hs_busy", slot_busy, busy_vec());
    n_spawn++;
    $display("spawn n=%0d hpos=%0d slot=%0d tries=%0d delay=%0d", n_spawn, hpos, slot, tries, ready_delay);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired total=%0d", total);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    step();
    do_reset();

    // First game at level 0; first spawn held off for 10 cycles.
    start_game(0);
    do_spawn(0, 10, 1'b0, 1'b0);

    // Constant lane: third spawn needs the full retry budget.
    do_reset();
    start_game(2);
    for (int i = 0; i < 3; i++) do_spawn(1, $urandom_range(0, 3), 1'b0, 1'b0);

    // Level 3 (7 frames): fill all slots, drop one, free slot 5, spawn into it.
    do_reset();
    start_game(3);
    for (int i = 0; i < 8; i++) do_spawn(0, $urandom_range(0, 2), 1'b0, 1'b0);
    do_spawn(0, 0, 1'b0, 1'b0);
    chk("drop_one", drop_cnt, 1);
    despawn(5);
    do_spawn(0, 1, 1'b0, 1'b0);
    chk("refill_slot5_busy", slot_busy, 8'hFF);

    // Abort while a request is pending, then restart.
    despawn(2);
    do_spawn(0, 3, 1'b0, 1'b1);
    start_game(1);

    // Random play with despawns and mid-count level changes.
    for (int i = 0; i < 24; i++) begin
      do_spawn(0, $urandom_range(0, 4), 1'b1, 1'b0);
      level = 2'($urandom_range(1, 3));
    end

    // Reset in the middle of a frame count.
    for (int i = 0; i < 2; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
